// File: rtl/pipelined_adder_if.sv
// Operand/result stream bundle for pipelined_adder. ovf exists only when ADDER_OVF_EN is defined.
interface pipelined_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef ADDER_OVF_EN
    logic             ovf;

    modport master (output in_valid, a, b, cin, sub, out_ready,
                    input  in_ready, out_valid, sum, cout, ovf);
    modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                    output in_ready, out_valid, sum, cout, ovf);
`else
    modport master (output in_valid, a, b, cin, sub, out_ready,
                    input  in_ready, out_valid, sum, cout);
    modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                    output in_ready, out_valid, sum, cout);
`endif
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit add/subtract: one STAGE_W-bit ripple slice per stage, carry registered between stages.
// Define ADDER_OVF_EN to add the registered signed-overflow output.
module pipelined_adder #(
    parameter int WIDTH   = 16,
    parameter int STAGE_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    pipelined_adder_if.slave io
);
    localparam int STAGES = WIDTH / STAGE_W;

    if (WIDTH % STAGE_W != 0) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH (%0d) must be a multiple of STAGE_W (%0d)", WIDTH, STAGE_W);
    end

    function automatic logic [STAGE_W:0] rca(input logic [STAGE_W-1:0] x,
                                             input logic [STAGE_W-1:0] y,
                                             input logic               c);
        logic [STAGE_W-1:0] s;
        logic               cc;
        cc = c;
        for (int i = 0; i < STAGE_W; i++) begin
            s[i] = x[i] ^ y[i] ^ cc;
            cc   = ((x[i] ^ y[i]) & cc) | (x[i] & y[i]);
        end
        return {cc, s};
    endfunction

    logic              adv;
    logic [WIDTH-1:0]  b_eff;
    logic [STAGES-1:0] vld_d, vld_q;

    // Whole-pipe stall: nothing moves unless the output slot is empty or being drained.
    assign adv         = !vld_q[STAGES-1] || io.out_ready;
    assign io.in_ready = adv;
    assign b_eff       = io.sub ? ~io.b : io.b;

    always_comb begin
        vld_d = vld_q;
        if (adv) vld_d = (vld_q << 1) | STAGES'(io.in_valid);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_q <= '0;
        else        vld_q <= vld_d;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        // Operand bits not yet consumed on entry to this stage.
        localparam int REM = WIDTH - k * STAGE_W;

        logic [REM-1:0]     a_in, b_in;
        logic [WIDTH-1:0]   s_in;
        logic               c_in;
        logic [STAGE_W:0]   slice;
        logic [WIDTH-1:0]   s_d, s_q;
        logic               c_d, c_q;

        if (k == 0) begin : g_first
            assign a_in = io.a;
            assign b_in = b_eff;
            assign s_in = '0;
            assign c_in = io.sub | io.cin;
        end else begin : g_next
            assign a_in = g_stg[k-1].g_fwd.ra_q;
            assign b_in = g_stg[k-1].g_fwd.rb_q;
            assign s_in = g_stg[k-1].s_q;
            assign c_in = g_stg[k-1].c_q;
        end

        assign slice = rca(a_in[STAGE_W-1:0], b_in[STAGE_W-1:0], c_in);

        always_comb begin
            s_d = s_q;
            c_d = c_q;
            if (adv) begin
                s_d                         = s_in;
                s_d[k*STAGE_W +: STAGE_W]   = slice[STAGE_W-1:0];
                c_d                         = slice[STAGE_W];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s_q <= '0;
                c_q <= 1'b0;
            end else begin
                s_q <= s_d;
                c_q <= c_d;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [REM-STAGE_W-1:0] ra_d, ra_q, rb_d, rb_q;

            always_comb begin
                ra_d = ra_q;
                rb_d = rb_q;
                if (adv) begin
                    ra_d = a_in[REM-1:STAGE_W];
                    rb_d = b_in[REM-1:STAGE_W];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ra_q <= '0;
                    rb_q <= '0;
                end else begin
                    ra_q <= ra_d;
                    rb_q <= rb_d;
                end
            end
        end
    end

    assign io.out_valid = vld_q[STAGES-1];
    assign io.sum       = g_stg[STAGES-1].s_q;
    assign io.cout      = g_stg[STAGES-1].c_q;

`ifdef ADDER_OVF_EN
    logic ovf_d, ovf_q, a_msb, b_msb;

    // The operand MSBs only meet the sum MSB in the last stage, so overflow resolves there.
    assign a_msb = g_stg[STAGES-1].a_in[STAGE_W-1];
    assign b_msb = g_stg[STAGES-1].b_in[STAGE_W-1];

    always_comb begin
        ovf_d = ovf_q;
        if (adv) ovf_d = (a_msb == b_msb) && (g_stg[STAGES-1].slice[STAGE_W-1] != a_msb);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

    assign io.ovf = ovf_q;
`endif
endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: directed vectors on (16,4), random streams on (16,4), (16,16), (32,8).
module tb_pipelined_adder;
    localparam int W  = 16;
    localparam int SW = 4;
    localparam int ST = W / SW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipelined_adder_if #(.WIDTH(16)) m  ();
    pipelined_adder_if #(.WIDTH(16)) m1 ();
    pipelined_adder_if #(.WIDTH(32)) m2 ();

    pipelined_adder #(.WIDTH(W),  .STAGE_W(SW)) dut  (.clk(clk), .rst_n(rst_n), .io(m.slave));
    pipelined_adder #(.WIDTH(16), .STAGE_W(16)) dut1 (.clk(clk), .rst_n(rst_n), .io(m1.slave));
    pipelined_adder #(.WIDTH(32), .STAGE_W(8))  dut2 (.clk(clk), .rst_n(rst_n), .io(m2.slave));

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    exp_t q0[$], q1[$], q2[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_out0 = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic note_fail(input string nm);
        n_chk++;
        $display("FAIL %s (t=%0t)", nm, $time);
    endtask

    function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub);
        logic [31:0] mask;
        logic [32:0] bb, r;
        exp_t        e;
        mask   = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        bb     = {1'b0, (sub ? ~b : b) & mask};
        r      = {1'b0, a & mask} + bb + {32'b0, sub | cin};
        e.sum  = r[31:0] & mask;
        e.cout = r[w];
        e.ovf  = (a[w-1] == bb[w-1]) && (r[w-1] != a[w-1]);
        return e;
    endfunction

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (rst_n && m.out_valid && m.out_ready) begin
            exp_t e;
            if (q0.size() == 0) note_fail("dut0 unexpected output");
            else begin
                e = q0.pop_front();
                n_out0++;
                chk("dut0 {cout,sum}", {m.cout, m.sum}, {e.cout, e.sum[15:0]});
`ifdef ADDER_OVF_EN
                chk("dut0 ovf", m.ovf, e.ovf);
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && m1.out_valid && m1.out_ready) begin
            exp_t e;
            if (q1.size() == 0) note_fail("dut1 unexpected output");
            else begin
                e = q1.pop_front();
                chk("dut1 {cout,sum}", {m1.cout, m1.sum}, {e.cout, e.sum[15:0]});
`ifdef ADDER_OVF_EN
                chk("dut1 ovf", m1.ovf, e.ovf);
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && m2.out_valid && m2.out_ready) begin
            exp_t e;
            if (q2.size() == 0) note_fail("dut2 unexpected output");
            else begin
                e = q2.pop_front();
                chk("dut2 {cout,sum}", {m2.cout, m2.sum}, {e.cout, e.sum});
`ifdef ADDER_OVF_EN
                chk("dut2 ovf", m2.ovf, e.ovf);
`endif
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send0(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic sub, input exp_t e);
        logic got = 1'b0;
        m.in_valid = 1'b1; m.a = a; m.b = b; m.cin = cin; m.sub = sub;
        for (int t = 0; t < 200 && !got; t++) begin
            @(negedge clk); got = m.in_ready;
            if (got) q0.push_back(e);
            @(posedge clk); #1;
        end
        if (!got) note_fail("dut0 send timeout");
    endtask

    task automatic send1(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
        logic got = 1'b0;
        m1.in_valid = 1'b1; m1.a = a; m1.b = b; m1.cin = cin; m1.sub = sub;
        for (int t = 0; t < 200 && !got; t++) begin
            @(negedge clk); got = m1.in_ready;
            if (got) q1.push_back(model(16, {16'b0, a}, {16'b0, b}, cin, sub));
            @(posedge clk); #1;
        end
        if (!got) note_fail("dut1 send timeout");
    endtask

    task automatic send2(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
        logic got = 1'b0;
        m2.in_valid = 1'b1; m2.a = a; m2.b = b; m2.cin = cin; m2.sub = sub;
        for (int t = 0; t < 200 && !got; t++) begin
            @(negedge clk); got = m2.in_ready;
            if (got) q2.push_back(model(32, a, b, cin, sub));
            @(posedge clk); #1;
        end
        if (!got) note_fail("dut2 send timeout");
    endtask

    task automatic drain0();
        for (int t = 0; t < 100 && q0.size() != 0; t++) @(posedge clk);
        #1;
        chk("dut0 drained", q0.size(), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [16:0] snap;
        int          lat, base;
        m.in_valid  = 1'b0; m.a  = '0; m.b  = '0; m.cin  = 1'b0; m.sub  = 1'b0; m.out_ready  = 1'b1;
        m1.in_valid = 1'b0; m1.a = '0; m1.b = '0; m1.cin = 1'b0; m1.sub = 1'b0; m1.out_ready = 1'b1;
        m2.in_valid = 1'b0; m2.a = '0; m2.b = '0; m2.cin = 1'b0; m2.sub = 1'b0; m2.out_ready = 1'b1;

        // reset state
        repeat (2) @(negedge clk);
        chk("reset out_valid", m.out_valid, 0);
        chk("reset {cout,sum}", {m.cout, m.sum}, 0);
`ifdef ADDER_OVF_EN
        chk("reset ovf", m.ovf, 0);
`endif
        @(posedge clk); #1; rst_n = 1'b1;
        #1 chk("in_ready after reset", m.in_ready, 1);

        // carry across all slices, with latency measurement
        send0(16'hFFFF, 16'h0001, 1'b0, 1'b0, exp_t'{32'h0000, 1'b1, 1'b0});
        m.in_valid = 1'b0;
        lat = 0;
        for (int t = 1; t <= 10 && lat == 0; t++) begin
            @(negedge clk);
            if (m.out_valid) lat = t;
        end
        chk("latency", lat, ST);
        drain0();

        // subtract, ovf corners, cin ignored under sub
        send0(16'h0005, 16'h0007, 1'b0, 1'b1, exp_t'{32'hFFFE, 1'b0, 1'b0});
        send0(16'h0007, 16'h0005, 1'b0, 1'b1, exp_t'{32'h0002, 1'b1, 1'b0});
        send0(16'h7FFF, 16'h0001, 1'b0, 1'b0, exp_t'{32'h8000, 1'b0, 1'b1});
        send0(16'h8000, 16'hFFFF, 1'b0, 1'b0, exp_t'{32'h7FFF, 1'b1, 1'b1});
        send0(16'h0010, 16'h0003, 1'b1, 1'b1, exp_t'{32'h000D, 1'b1, 1'b0});
        send0(16'h8000, 16'h0001, 1'b1, 1'b1, exp_t'{32'h7FFF, 1'b1, 1'b1});
        m.in_valid = 1'b0;
        drain0();

        // back-to-back stream with a 3-cycle stall
        base = n_out0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    logic [15:0] iv;
                    iv = 16'(i);
                    send0(iv, iv, iv[0], 1'b0, exp_t'{32'(2 * i + i % 2), 1'b0, 1'b0});
                end
                m.in_valid = 1'b0;
            end
            begin
                repeat (5) @(posedge clk);
                #1 m.out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    chk("stall in_ready", m.in_ready, 0);
                    chk("stall out_valid", m.out_valid, 1);
                    if (s == 0) snap = {m.cout, m.sum};
                    else chk("stall output stable", {m.cout, m.sum}, snap);
                    @(posedge clk); #1;
                end
                m.out_ready = 1'b1;
            end
        join
        drain0();
        chk("stream result count", n_out0 - base, 8);

        // asynchronous reset with ops in flight
        send0(16'h1111, 16'h2222, 1'b0, 1'b0, exp_t'{32'h3333, 1'b0, 1'b0});
        send0(16'h0101, 16'h0202, 1'b0, 1'b0, exp_t'{32'h0303, 1'b0, 1'b0});
        send0(16'hA000, 16'h6000, 1'b0, 1'b0, exp_t'{32'h0000, 1'b1, 1'b0});
        send0(16'h0F0F, 16'h0101, 1'b1, 1'b0, exp_t'{32'h1011, 1'b0, 1'b0});
        m.in_valid = 1'b0;
        #1 chk("in-flight out_valid", m.out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("async reset out_valid", m.out_valid, 0);
        chk("async reset {cout,sum}", {m.cout, m.sum}, 0);
        q0.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        base = n_out0;
        send0(16'h1234, 16'h1111, 1'b0, 1'b0, exp_t'{32'h2345, 1'b0, 1'b0});
        m.in_valid = 1'b0;
        repeat (12) @(posedge clk);
        drain0();
        chk("post-reset result count", n_out0 - base, 1);

        // random regression on all three configurations
        fork
            begin
                for (int i = 0; i < 80; i++) begin
                    logic [15:0] ra, rb;
                    logic        rc, rs;
                    m.in_valid = 1'b0;
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
                    send0(ra, rb, rc, rs, model(16, {16'b0, ra}, {16'b0, rb}, rc, rs));
                end
                m.in_valid = 1'b0;
                for (int t = 0; t < 500 && q0.size() != 0; t++) begin
                    @(posedge clk); #1 m.out_ready = ($urandom_range(0, 3) != 0);
                end
                m.out_ready = 1'b1;
            end
            begin
                for (int t = 0; t < 400; t++) begin
                    @(posedge clk); #1 m.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
            begin
                for (int i = 0; i < 80; i++) begin
                    m1.in_valid = 1'b0;
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    send1(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
                end
                m1.in_valid = 1'b0;
                for (int t = 0; t < 500 && q1.size() != 0; t++) begin
                    @(posedge clk); #1 m1.out_ready = ($urandom_range(0, 3) != 0);
                end
                m1.out_ready = 1'b1;
            end
            begin
                for (int t = 0; t < 400; t++) begin
                    @(posedge clk); #1 m1.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
            begin
                for (int i = 0; i < 80; i++) begin
                    m2.in_valid = 1'b0;
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    send2($urandom, $urandom, 1'($urandom), 1'($urandom));
                end
                m2.in_valid = 1'b0;
                for (int t = 0; t < 500 && q2.size() != 0; t++) begin
                    @(posedge clk); #1 m2.out_ready = ($urandom_range(0, 3) != 0);
                end
                m2.out_ready = 1'b1;
            end
            begin
                for (int t = 0; t < 400; t++) begin
                    @(posedge clk); #1 m2.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        m.out_ready = 1'b1; m1.out_ready = 1'b1; m2.out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("dut0 queue empty", q0.size(), 0);
        chk("dut1 queue empty", q1.size(), 0);
        chk("dut2 queue empty", q2.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined add/subtract unit that succeeds the fixed 4-bit ripple-carry adder.
- Splits a WIDTH-bit operation into STAGE_W-bit ripple slices, one slice per pipeline stage. Carry is registered between stages.
- Streams one operation per cycle under a valid/ready handshake with backpressure.
- Sits between operand producers and result consumers in the datapath wherever wide adds must close timing.

Parameters:
- WIDTH, 16, operand/result width in bits.
- STAGE_W, 4, bits resolved per pipeline stage. WIDTH % STAGE_W must be 0, else elaboration error.
- STAGES (derived, not overridable), WIDTH/STAGE_W, pipeline depth and latency in cycles.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands/mode present this cycle.
- in_ready  output  1  unit accepts operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  0: a+b+cin; 1: a-b (a + ~b + 1).
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result modulo 2^WIDTH.
- cout  output  1  carry out of MSB. When sub=1, cout=1 means no borrow (a>=b unsigned).
- ovf  output  1  signed overflow; present only with ADDER_OVF_EN.

Behaviour:
- Reset:
  - Clock is clk; reset is rst_n, asynchronous assert, active-low. Deassertion is synchronised externally.
  - While rst_n=0, all stage valids clear, out_valid=0, sum=0, cout=0, ovf=0.
  - in_ready=1 combinationally once rst_n=1.
  - Reset mid-operation discards all in-flight operations. Nothing is emitted for them.
- Advance and handshake:
  - adv = !out_valid | out_ready. Every stage register, including valid bits, updates only when adv=1. The pipeline stalls as a whole; there is no bubble collapse.
  - in_ready = adv (combinational). Input is accepted when in_valid & in_ready.
  - A cycle with in_valid=0 and adv=1 inserts a bubble (stage valid=0).
  - out_valid/sum/cout/ovf hold stable while out_valid=1 & out_ready=0.
- Stage k (k=0..STAGES-1):
  - Adds slice k of a and b' (b' = sub ? ~b : b) with carry c_k. c_0 = sub ? 1 : cin; c_k for k>0 is the carry registered by stage k-1.
  - Slice k of the operands is carried forward, delayed through k registers. Completed lower slices are carried forward, delayed to align with the last stage.
- Latency and throughput:
  - With no stall, an operation accepted at clock edge e produces out_valid=1 after edge e+STAGES-1, i.e. STAGES cycles.
  - Throughput is 1 op/cycle.
  - Results leave in acceptance order.
- Arithmetic:
  - sum = (a + b' + c_0) mod 2^WIDTH. cout = bit WIDTH of that sum.
  - Slices are ripple-carry full adders: s = x^y^c, co = ((x^y)&c)|(x&y).
- Degenerate cases:
  - STAGE_W = WIDTH gives STAGES=1: single registered stage, latency 1.
  - Simultaneous accept and emit (in_valid, out_valid, out_ready all 1) is legal every cycle.

Optional Feature:
- Macro: ADDER_OVF_EN.
- Defined: ovf port exists and is registered alongside sum. ovf=1 when the MSBs of a and b' are equal and the sum MSB differs from them. Reset value is 0. ovf holds under stall like sum.
- Undefined: ovf port and its logic are absent. All other behaviour is identical.

Test Plan:
- WIDTH=16, STAGE_W=4, out_ready=1: a=0xFFFF, b=0x0001, cin=0, sub=0 -> after 4 cycles sum=0x0000, cout=1 (ovf=0).
- Subtract: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0. Then a=0x0007, b=0x0005, sub=1 -> sum=0x0002, cout=1.
- ADDER_OVF_EN defined: a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, ovf=1. a=0x8000, b=0xFFFF -> sum=0x7FFF, cout=1, ovf=1.
- Stream 8 back-to-back ops a=i, b=i, cin=i[0]; hold out_ready=0 for 3 cycles mid-stream:
  - in_ready=0 during the stall.
  - Outputs stay stable during the stall.
  - Results 2i+i[0] appear in order with no loss or duplication.
- Assert rst_n=0 asynchronously with 3 ops in flight:
  - out_valid drops immediately and sum=0.
  - After release, a new op 0x1234+0x1111 yields 0x2345 after 4 cycles and no stale results appear.
- Random regression against a reference model with bubbles and random out_ready, for (WIDTH,STAGE_W) = (16,4), (16,16), (32,8).
